// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command sequencer and its Wishbone bridge.
// Holds FSM states, command word layout and SPI master register map.
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int CMD_WE_BIT = 32;
    localparam int CMD_W      = 34;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    localparam logic [7:0] SPI_RX0    = 8'h00;
    localparam logic [7:0] SPI_TX0    = 8'h00;
    localparam logic [7:0] SPI_CTRL   = 8'h10;
    localparam logic [7:0] SPI_DIVIDE = 8'h14;
    localparam logic [7:0] SPI_SS     = 8'h18;

endpackage

// File: rtl/spi_cmd_pending.sv
// Single-entry command holding register.
// Accepts a load when empty or when the entry is taken the same cycle.
module spi_cmd_pending #(
    parameter int W = 41
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         take_i,
    input  logic         clr_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         ovf_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         ovf_q, ovf_d;
    logic         accept;
    logic         drop;

    assign accept = load_i & (~valid_q | take_i);
    assign drop   = load_i & valid_q & ~take_i;

    // Next entry state; an overflow set wins over a clear.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (take_i) begin
            valid_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_i) begin
            ovf_d = 1'b0;
        end
    end

    // Entry and sticky overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/spi_wb_cmd_bridge.sv
// Turns strobed register commands into single Wishbone classic cycles.
// One command can wait in a pending slot while a cycle is in flight.
module spi_wb_cmd_bridge
    import spi_cmd_pkg::*;
#(
    parameter int ADR_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_stb,
    input  logic [ADR_W-1:0] adr,
    input  logic [33:0]      cmd_word,
    input  logic             clr_flags,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [31:0]      wb_dat_o,
    output logic [3:0]       wb_sel_o,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    output logic [31:0]      rd_dat,
    output logic             rd_valid,
    output logic             busy,
    output logic             ovf,
    output logic             bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int ENT_W = ADR_W + 33;

    state_e           state_q, state_d;
    logic             stb_q;
    logic             cmd_edge;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [31:0]      rd_dat_q, rd_dat_d;
    logic             rd_valid_q, rd_valid_d;
    logic             bus_err_q, bus_err_d;

    logic             in_idle;
    logic             in_req;
    logic             tmo_hit;
    logic             term_ack;
    logic             term_err;
    logic             term_tmo;
    logic             launch;

    logic             pend_valid;
    logic             pend_load;
    logic             pend_take;
    logic             pend_ovf;
    logic [ENT_W-1:0] pend_ent;
    logic [ENT_W-1:0] new_ent;
    logic [ENT_W-1:0] launch_ent;

    logic             unused_cmd_msb;

    assign unused_cmd_msb = cmd_word[CMD_W-1];

    assign cmd_edge = cmd_stb & ~stb_q;
    assign in_idle  = (state_q == ST_IDLE);
    assign in_req   = (state_q == ST_REQ);
    assign tmo_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign term_ack = in_req & wb_ack_i;
    assign term_err = in_req & ~wb_ack_i & wb_err_i;
    assign term_tmo = in_req & ~wb_ack_i & ~wb_err_i & tmo_hit;
    assign launch   = in_idle & (pend_valid | cmd_edge);

    assign new_ent    = {cmd_word[CMD_WE_BIT], adr, cmd_word[31:0]};
    assign launch_ent = pend_valid ? pend_ent : new_ent;

    // A queued entry launches first; a same-cycle edge refills the slot.
    assign pend_take = in_idle & pend_valid;
    assign pend_load = cmd_edge & (~in_idle | pend_valid);

    spi_cmd_pending #(
        .W (ENT_W)
    ) u_pending (
        .clk     (clk),
        .rst     (rst),
        .load_i  (pend_load),
        .take_i  (pend_take),
        .clr_i   (clr_flags),
        .data_i  (new_ent),
        .valid_o (pend_valid),
        .data_o  (pend_ent),
        .ovf_o   (pend_ovf)
    );

    // Command strobe history for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stb_q <= 1'b0;
        end else begin
            stb_q <= cmd_stb;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: ack beats err beats timeout, all end in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (term_ack | term_err | term_tmo) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: bus strobes and select only while a request is open.
    always_comb begin
        wb_cyc_o = in_req;
        wb_stb_o = in_req;
        wb_sel_o = in_req ? WB_SEL_ALL : 4'h0;
    end

    // Datapath next state: bus fields, read capture, timer, error flag.
    always_comb begin
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rd_dat_d   = rd_dat_q;
        rd_valid_d = 1'b0;
        bus_err_d  = bus_err_q;
        cnt_d      = in_req ? cnt_q + CNT_W'(1) : '0;
        if (launch) begin
            we_d  = launch_ent[ENT_W-1];
            adr_d = launch_ent[ENT_W-2:32];
            dat_d = launch_ent[31:0];
        end
        if (term_ack & ~we_q) begin
            rd_dat_d   = wb_dat_i;
            rd_valid_d = 1'b1;
        end
        if (term_err | term_tmo) begin
            bus_err_d = 1'b1;
        end else if (clr_flags) begin
            bus_err_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rd_dat_q   <= '0;
            rd_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rd_dat_q   <= rd_dat_d;
            rd_valid_q <= rd_valid_d;
            bus_err_q  <= bus_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign rd_dat   = rd_dat_q;
    assign rd_valid = rd_valid_q;
    assign bus_err  = bus_err_q;
    assign ovf      = pend_ovf;
    assign busy     = ~in_idle | pend_valid;

endmodule

// File: tb/tb_spi_wb_cmd_bridge.sv
// Bench for spi_wb_cmd_bridge: table of single transactions, then
// hand sequences for queueing, overflow, timeout, error and reset.
module tb_spi_wb_cmd_bridge;
    import spi_cmd_pkg::*;

    localparam int ADR_W   = 8;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_stb = 1'b0;
    logic [ADR_W-1:0] adr = '0;
    logic [33:0]      cmd_word = '0;
    logic             clr_flags = 1'b0;
    logic             wb_cyc_o, wb_stb_o, wb_we_o;
    logic [ADR_W-1:0] wb_adr_o;
    logic [31:0]      wb_dat_o;
    logic [3:0]       wb_sel_o;
    logic [31:0]      wb_dat_i = '0;
    logic             wb_ack_i = 1'b0;
    logic             wb_err_i = 1'b0;
    logic [31:0]      rd_dat;
    logic             rd_valid, busy, ovf, bus_err;

    int errors = 0;
    int checks = 0;
    int txn_cnt = 0;
    int rv_cnt = 0;
    logic cyc_prev = 1'b0;

    spi_wb_cmd_bridge #(
        .ADR_W   (ADR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_stb   (cmd_stb),
        .adr       (adr),
        .cmd_word  (cmd_word),
        .clr_flags (clr_flags),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .rd_dat    (rd_dat),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .ovf       (ovf),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // Count bus cycles started and read-valid pulses seen.
    always @(posedge clk) begin
        cyc_prev <= wb_cyc_o;
        if (wb_cyc_o && !cyc_prev) txn_cnt <= txn_cnt + 1;
        if (rd_valid) rv_cnt <= rv_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  adr;
        logic [33:0] word;
        int          hold;
        int          waits;
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_dat;
        logic        exp_rv;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, r0, n;

        vecs[0] = '{SPI_DIVIDE, 34'h1_0000_0000, 2, 0, 32'h1234_5678,
                    1'b1, 32'h0000_0000, 1'b0};
        vecs[1] = '{SPI_RX0, 34'h2_0000_0000, 1, 3, 32'hDEAD_BEEF,
                    1'b0, 32'h0000_0000, 1'b1};
        vecs[2] = '{SPI_SS, 34'h3_0000_00A5, 1, 1, 32'hFFFF_FFFF,
                    1'b1, 32'h0000_00A5, 1'b0};
        vecs[3] = '{SPI_CTRL, 34'h0_1111_2222, 3, 2, 32'h0000_3010,
                    1'b0, 32'h1111_2222, 1'b1};

        // Reset state
        tick();
        tick();
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_flags", {ovf, bus_err}, 0);
        #3 rst = 1'b1;
        tick();
        tick();

        // Table of single transactions
        for (int i = 0; i < 4; i++) begin
            t0 = txn_cnt;
            r0 = rv_cnt;
            cmd_stb = 1'b1;
            adr = vecs[i].adr;
            cmd_word = vecs[i].word;
            tick();
            chk("v_cyc", wb_cyc_o, 1);
            chk("v_stb", wb_stb_o, 1);
            chk("v_adr", wb_adr_o, vecs[i].adr);
            chk("v_we", wb_we_o, vecs[i].exp_we);
            chk("v_dat", wb_dat_o, vecs[i].exp_dat);
            chk("v_sel", wb_sel_o, 4'hF);
            cmd_stb = (vecs[i].hold > 1);
            for (int k = 0; k < vecs[i].waits; k++) tick();
            chk("v_cyc_held", wb_cyc_o, 1);
            wb_ack_i = 1'b1;
            wb_dat_i = vecs[i].rdata;
            tick();
            wb_ack_i = 1'b0;
            wb_dat_i = '0;
            cmd_stb = 1'b0;
            chk("v_cyc_drop", wb_cyc_o, 0);
            chk("v_rdv", rd_valid, vecs[i].exp_rv);
            if (vecs[i].exp_rv) chk("v_rdat", rd_dat, vecs[i].rdata);
            tick();
            chk("v_rdv_end", rd_valid, 0);
            tick();
            tick();
            tick();
            chk("v_txn", txn_cnt - t0, 1);
            chk("v_rvcnt", rv_cnt - r0, vecs[i].exp_rv);
            chk("v_busy", busy, 0);
        end

        // Ack outside a request is ignored
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hBAD0_BAD0;
        tick();
        wb_ack_i = 1'b0;
        tick();
        chk("idle_ack_rdv", rd_valid, 0);
        chk("idle_ack_busy", busy, 0);

        // Back-to-back with overflow
        t0 = txn_cnt;
        cmd_stb = 1'b1;
        adr = SPI_CTRL;
        cmd_word = 34'h1_0000_3010;
        tick();
        cmd_stb = 1'b0;
        tick();
        cmd_stb = 1'b1;
        adr = SPI_TX0;
        cmd_word = 34'h1_0000_2ABC;
        tick();
        cmd_stb = 1'b0;
        chk("b2b_ovf0", ovf, 0);
        tick();
        cmd_stb = 1'b1;
        adr = SPI_SS;
        cmd_word = 34'h1_0000_00FF;
        tick();
        cmd_stb = 1'b0;
        chk("b2b_ovf1", ovf, 1);
        chk("b2b_adr_hold", wb_adr_o, SPI_CTRL);
        chk("b2b_dat_hold", wb_dat_o, 32'h0000_3010);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        chk("b2b_done_cyc", wb_cyc_o, 0);
        chk("b2b_done_busy", busy, 1);
        tick();
        chk("b2b_idle_cyc", wb_cyc_o, 0);
        tick();
        chk("b2b_2nd_cyc", wb_cyc_o, 1);
        chk("b2b_2nd_adr", wb_adr_o, SPI_TX0);
        chk("b2b_2nd_dat", wb_dat_o, 32'h0000_2ABC);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("b2b_txn", txn_cnt - t0, 2);
        chk("b2b_busy", busy, 0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("b2b_clr", ovf, 0);

        // Timeout on a read
        r0 = rv_cnt;
        cmd_stb = 1'b1;
        adr = SPI_RX0;
        cmd_word = 34'h0_0000_0000;
        tick();
        cmd_stb = 1'b0;
        n = 0;
        while (wb_cyc_o && n < 200) begin
            n++;
            tick();
        end
        chk("tmo_len", n, TIMEOUT);
        chk("tmo_berr", bus_err, 1);
        tick();
        tick();
        chk("tmo_norv", rv_cnt - r0, 0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("tmo_clr", bus_err, 0);

        // Error in second request cycle, with a coincident clear
        r0 = rv_cnt;
        cmd_stb = 1'b1;
        tick();
        cmd_stb = 1'b0;
        tick();
        wb_err_i = 1'b1;
        clr_flags = 1'b1;
        tick();
        wb_err_i = 1'b0;
        clr_flags = 1'b0;
        chk("err_cyc", wb_cyc_o, 0);
        chk("err_berr", bus_err, 1);
        chk("err_rdv", rd_valid, 0);
        tick();
        tick();
        chk("err_norv", rv_cnt - r0, 0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("err_clr", bus_err, 0);

        // Edge with ack, and ack with err on a read
        cmd_stb = 1'b1;
        adr = SPI_RX0;
        cmd_word = 34'h0_0000_0000;
        tick();
        cmd_stb = 1'b0;
        tick();
        cmd_stb = 1'b1;
        adr = SPI_DIVIDE;
        cmd_word = 34'h1_0000_0055;
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        wb_dat_i = 32'hCAFE_F00D;
        tick();
        cmd_stb = 1'b0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        chk("sim_cyc", wb_cyc_o, 0);
        chk("sim_rdv", rd_valid, 1);
        chk("sim_rdat", rd_dat, 32'hCAFE_F00D);
        chk("sim_berr", bus_err, 0);
        chk("sim_busy", busy, 1);
        tick();
        chk("sim_idle", wb_cyc_o, 0);
        tick();
        chk("sim_2nd_cyc", wb_cyc_o, 1);
        chk("sim_2nd_adr", wb_adr_o, SPI_DIVIDE);
        chk("sim_2nd_we", wb_we_o, 1);
        chk("sim_2nd_dat", wb_dat_o, 32'h0000_0055);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        tick();
        tick();

        // Reset during a request with a full pending slot
        cmd_stb = 1'b1;
        adr = SPI_SS;
        cmd_word = 34'h1_0000_0001;
        tick();
        cmd_stb = 1'b0;
        tick();
        cmd_stb = 1'b1;
        adr = SPI_CTRL;
        tick();
        cmd_stb = 1'b0;
        tick();
        cmd_stb = 1'b1;
        tick();
        cmd_stb = 1'b0;
        chk("mr_pre_cyc", wb_cyc_o, 1);
        chk("mr_pre_ovf", ovf, 1);
        #2 rst = 1'b0;
        #1;
        chk("mr_cyc", wb_cyc_o, 0);
        chk("mr_stb", wb_stb_o, 0);
        chk("mr_sel", wb_sel_o, 0);
        chk("mr_bus", {wb_we_o, wb_adr_o, wb_dat_o}, 0);
        chk("mr_busy", busy, 0);
        chk("mr_flags", {ovf, bus_err, rd_valid}, 0);
        tick();
        #3 rst = 1'b1;
        t0 = txn_cnt;
        for (int k = 0; k < 6; k++) tick();
        chk("mr_no_txn", txn_cnt - t0, 0);
        chk("mr_idle", {wb_cyc_o, busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_wb_cmd_bridge.md
Name: spi_wb_cmd_bridge

Overview:
- Downstream stage of the AD796x-to-AD5453 command sequencer.
- Takes its strobed register commands (adr, cmd_word, cmd_stb) and runs single Wishbone classic cycles on the SPI master core.
- Buffers one command while a cycle is in flight, returns read data, and flags overflow, bus error and timeout.

Parameters:
- ADR_W, 8, width of command address and wb_adr_o.
- TIMEOUT, 64, max cycles with cyc/stb high awaiting ack/err before abort (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- cmd_stb  input  1  command strobe; may stay high for several cycles.
- adr  input  ADR_W  register address of command.
- cmd_word  input  34  [32]=write enable, [31:0]=write data, [33] ignored.
- clr_flags  input  1  synchronous clear of sticky flags.
- wb_cyc_o  output  1  Wishbone cycle.
- wb_stb_o  output  1  Wishbone strobe.
- wb_we_o  output  1  write enable.
- wb_adr_o  output  ADR_W  address.
- wb_dat_o  output  32  write data.
- wb_sel_o  output  4  byte select.
- wb_dat_i  input  32  read data.
- wb_ack_i  input  1  cycle acknowledge.
- wb_err_i  input  1  cycle error.
- rd_dat  output  32  captured read data.
- rd_valid  output  1  one-cycle pulse when rd_dat is updated.
- busy  output  1  high when state != IDLE or pending entry valid.
- ovf  output  1  sticky: command dropped.
- bus_err  output  1  sticky: wb_err_i seen or timeout.

Behaviour:
- Reset (rst low, async) clears every output, both registers, state, the timeout counter and the stb history.
  - wb_sel_o resets to 0 and is driven 4'hF only while wb_cyc_o is high.
- Command acceptance:
  - A command is the rising edge of cmd_stb: cmd_stb high this cycle, low last cycle.
  - adr and cmd_word are sampled in that same cycle.
  - A level held high for N cycles yields exactly one command.
- States:
  - IDLE:
    - If a pending entry is valid, launch it. Pending has priority over a same-cycle new edge; the new edge is written into the freed pending slot.
    - Otherwise a new edge launches directly.
    - Launch = load the wb_* registers and go to REQ.
  - REQ:
    - wb_cyc_o = wb_stb_o = 1, with adr/data/we held constant.
    - The timeout counter counts cycles spent in REQ.
  - DONE:
    - One cycle with cyc/stb low, then return to IDLE.
    - This guarantees at least one idle bus cycle between transactions.
- Latency:
  - Edge in cycle N with state IDLE and pending empty: cyc/stb high from cycle N+1.
  - ack sampled high in cycle M: cyc/stb low in cycle M+1 (state DONE).
  - For a read (we=0), rd_dat = wb_dat_i sampled at M, and rd_valid is high in cycle M+1 only.
  - Writes never pulse rd_valid.
- Termination priority when sampled in the same REQ cycle: ack > err > timeout.
  - err: terminate as for ack, set bus_err, no rd_valid.
  - Timeout: if the counter reaches TIMEOUT-1 with no ack/err, terminate next cycle, set bus_err, no rd_valid.
- Edge while state != IDLE:
  - Pending empty: store it in pending.
  - Pending full: drop the command and set ovf.
  - An edge in the same cycle as ack goes to pending.
- clr_flags clears ovf and bus_err. If clr_flags coincides with a setting event, the set wins.
- wb_ack_i or wb_err_i while not in REQ: ignored.
- Reset mid-cycle: cyc/stb drop immediately (async) and the pending entry is lost.

Decomposition:
- Shared package spi_cmd_pkg:
  - state enum (IDLE/REQ/DONE).
  - CMD_WE_BIT=32, CMD_W=34, WB_SEL_ALL=4'hF.
  - SPI master register addresses (RX0/TX0=8'h00, CTRL=8'h10, DIVIDE=8'h14, SS=8'h18), so the sequencer and this block share them.
- One sub-module: spi_cmd_pending, a single-entry holding register with valid, load, take and overflow flag.
- Edge detection, FSM and counter stay in the top module.

Test Plan:
- Write from IDLE:
  - Stimulus: cmd_stb high 2 cycles, adr=8'h14, cmd_word=34'h100000000, ack 1 cycle after stb.
  - Expect: one cycle with we=1, adr=8'h14, dat=0, sel=F; no rd_valid; exactly one transaction despite the 2-cycle strobe.
- Read:
  - Stimulus: adr=8'h00, cmd_word[32]=0, slave returns 32'hDEADBEEF with ack after 3 wait cycles.
  - Expect: rd_valid one cycle, rd_dat=32'hDEADBEEF, cyc low the cycle after ack.
- Back-to-back:
  - Stimulus: CTRL write 34'h100003010, then TX0 write 34'h100002ABC issued while the first is in REQ.
  - Expect: second cycle starts after DONE+IDLE, in order; ovf=0.
  - Stimulus: third edge during the first cycle with pending full.
  - Expect: ovf=1, only two bus cycles; clr_flags -> ovf=0.
- Timeout / error:
  - Stimulus: no ack with TIMEOUT=64.
  - Expect: cyc drops after exactly 64 REQ cycles, bus_err=1, no rd_valid.
  - Stimulus: wb_err_i in cycle 2.
  - Expect: immediate terminate, bus_err=1.
- Simultaneity: new edge in the same cycle as ack -> held in pending, launched after DONE; ack sampled with err -> treated as ack (rd_valid for a read), bus_err stays 0.
- Reset mid-operation:
  - Stimulus: rst low during REQ with pending valid.
  - Expect: all outputs 0 asynchronously; after release no transaction occurs until a new cmd_stb edge.
